fsmd_result_reader: RTL and testbench

Consumer for the FSM+D datapath: watches the datapath's present-state bus, and when the datapath enters its done state it snapshots R1, R2 and R3. It then streams the three results out one word per transfer over a valid/ready handshake. It sits between `top_FSMplusD` and any downstream sink (UART formatter, checker, display), reading results that the datapath only writes.

---
 rtl/fsmd_result_reader_pkg.sv | 24 ++
 rtl/fsmd_result_reader_if.sv | 33 +++
 rtl/fsmd_result_reader_done_detect.sv | 35 +++
 rtl/fsmd_result_reader.sv | 131 +++++++++++++
 tb/tb_fsmd_result_reader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fsmd_result_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsmd_pkg
//  Purpose  : Shared types and constants for the FSM+D datapath and its
//             result reader. DONE_STATE lives here so the producer and the
//             consumer agree on the "results valid" encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package fsmd_pkg;

    localparam int         c_DW         = 4;
    localparam int         c_STW        = 4;
    localparam logic [3:0] c_DONE_STATE = 4'd3;

    // Output sequencer states: one state per streamed result word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2,
        SEND3 = 2'd3
    } state_t;

endpackage : fsmd_pkg
`default_nettype wire

// File: rtl/fsmd_result_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsmd_result_reader_if
//  Purpose  : valid/ready result stream carrying one DW-bit word per transfer,
//             with a last marker on the third word of each frame.
//  Revision : 1.0 - initial release
// ============================================================================
interface fsmd_result_reader_if
    import fsmd_pkg::*;
#(
    parameter int DW = c_DW
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface : fsmd_result_reader_if
`default_nettype wire

// File: rtl/fsmd_result_reader_done_detect.sv
`default_nettype none
// ============================================================================
//  Module   : fsmd_done_detect
//  Purpose  : Rising-entry detector on the datapath present-state bus. Flags
//             the single cycle in which PS first equals DONE_STATE.
//  Revision : 1.0 - initial release
// ============================================================================
module fsmd_done_detect
    import fsmd_pkg::*;
#(
    parameter int             STW        = c_STW,
    parameter logic [STW-1:0] DONE_STATE = STW'(c_DONE_STATE)
) (
    input  wire logic           clock,
    input  wire logic           reset,
    input  wire logic [STW-1:0] PS,
    output logic                done_evt
);

    logic [STW-1:0] r_prev_ps;

    // Remember last cycle's PS; resets to 0 so a PS already parked in the
    // done state at reset release still produces one event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev_ps <= '0;
        end else begin
            r_prev_ps <= PS;
        end
    end

    assign done_evt = (PS == DONE_STATE) && (r_prev_ps != DONE_STATE);

endmodule : fsmd_done_detect
`default_nettype wire

// File: rtl/fsmd_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fsmd_result_reader
//  Purpose  : Snapshots R1..R3 when the datapath enters its done state and
//             streams the three words out over valid/ready. Events arriving
//             while a frame is still in flight are dropped and flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module fsmd_result_reader
    import fsmd_pkg::*;
#(
    parameter int             DW         = c_DW,
    parameter int             STW        = c_STW,
    parameter logic [STW-1:0] DONE_STATE = STW'(c_DONE_STATE)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [DW-1:0]    R1,
    input  wire logic [DW-1:0]    R2,
    input  wire logic [DW-1:0]    R3,
    input  wire logic [STW-1:0]   PS,
    fsmd_result_reader_if.master  bus,
    output logic                  busy,
    output logic                  overrun,
    input  wire logic             clr_overrun,
    output logic [7:0]            frames
);

    state_t        r_state;
    logic [DW-1:0] r_sh2;
    logic [DW-1:0] r_sh3;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_overrun;
    logic [7:0]    r_frames;

    logic          w_done_evt;
    logic          w_xfer;
    logic          w_accept;
    logic          w_drop;

    fsmd_done_detect #(
        .STW        (STW),
        .DONE_STATE (DONE_STATE)
    ) u_done_detect (
        .clock    (clock),
        .reset    (reset),
        .PS       (PS),
        .done_evt (w_done_evt)
    );

    // A transfer depends only on the registered valid, so out_ready never
    // reaches an output combinationally. An event is accepted from IDLE or
    // when it lands on the final transfer of the current frame.
    assign w_xfer   = r_valid && bus.out_ready;
    assign w_accept = w_done_evt &&
                      ((r_state == IDLE) || ((r_state == SEND3) && w_xfer));
    assign w_drop   = w_done_evt && !w_accept;

    // Sequencer, shadow registers and registered stream outputs. R1 goes
    // straight into the output word, so only R2 and R3 need shadows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sh2   <= '0;
            r_sh3   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= SEND1;
                r_sh2   <= R2;
                r_sh3   <= R3;
                r_data  <= R1;
                r_valid <= 1'b1;
                r_last  <= 1'b0;
            end else if (w_xfer) begin
                case (r_state)
                    SEND1: begin
                        r_state <= SEND2;
                        r_data  <= r_sh2;
                    end
                    SEND2: begin
                        r_state <= SEND3;
                        r_data  <= r_sh3;
                        r_last  <= 1'b1;
                    end
                    SEND3: begin
                        r_state <= IDLE;
                        r_data  <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky overrun (a new drop beats a clear) and the completed-frame count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
            r_frames  <= 8'd0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
            if (w_xfer && (r_state == SEND3)) begin
                r_frames <= r_frames + 8'd1;
            end
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign busy          = (r_state != IDLE);
    assign overrun       = r_overrun;
    assign frames        = r_frames;

endmodule : fsmd_result_reader
`default_nettype wire

// File: tb/tb_fsmd_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsmd_result_reader
//  Purpose  : Self-checking bench for fsmd_result_reader. A queue of pending
//             words models the stream; it is compared every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsmd_result_reader;

    logic       clock;
    logic       reset;
    logic [3:0] R1, R2, R3;
    logic [3:0] PS;
    logic       clr_overrun;
    logic       busy;
    logic       overrun;
    logic [7:0] frames;

    int n_tests = 0;
    int n_fail  = 0;

    fsmd_result_reader_if #(.DW(4)) bus ();

    fsmd_result_reader #(
        .DW         (4),
        .STW        (4),
        .DONE_STATE (4'd3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .R1          (R1),
        .R2          (R2),
        .R3          (R3),
        .PS          (PS),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .frames      (frames)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] d;
        logic       l;
    } word_t;

    word_t      m_q[$];
    logic [3:0] m_prev;
    logic       m_ovr;
    logic [7:0] m_frames;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev   = 4'd0;
        m_ovr    = 1'b0;
        m_frames = 8'd0;
    endtask

    // One clock of the model, using the inputs the next edge will sample.
    task automatic model_update();
        logic  evt;
        logic  drop;
        word_t w;
        evt  = (PS == 4'd3) && (m_prev != 4'd3);
        drop = 1'b0;
        if (m_q.size() != 0 && bus.out_ready) begin
            w = m_q.pop_front();
            if (w.l) m_frames = m_frames + 8'd1;
        end
        if (evt) begin
            if (m_q.size() == 0) begin
                m_q.push_back('{d: R1, l: 1'b0});
                m_q.push_back('{d: R2, l: 1'b0});
                m_q.push_back('{d: R3, l: 1'b1});
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
        m_prev = PS;
    endtask

    task automatic check_all();
        chk("valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("data", {28'd0, bus.out_data}, {28'd0, m_q[0].d});
            chk("last", {31'd0, bus.out_last}, {31'd0, m_q[0].l});
        end else begin
            chk("last_idle", {31'd0, bus.out_last}, 32'd0);
        end
        chk("busy", {31'd0, busy}, {31'd0, m_q.size() != 0});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("frames", {24'd0, frames}, {24'd0, m_frames});
    endtask

    // Called at a falling edge: apply inputs, advance model, check next cycle.
    task automatic step(input logic [3:0] ps_v, input logic rdy, input logic clr);
        PS            = ps_v;
        bus.out_ready = rdy;
        clr_overrun   = clr;
        model_update();
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, held two cycles, released at a
    // falling edge. Outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_data", {28'd0, bus.out_data}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        check_all();
    endtask

    task automatic set_r(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        R1 = a; R2 = b; R3 = c;
    endtask

    initial begin
        reset = 1'b1; PS = 4'd0; clr_overrun = 1'b0; bus.out_ready = 1'b0;
        set_r(4'd0, 4'd0, 4'd0);
        model_reset();
        @(negedge clock);
        do_reset();

        // Basic frame
        set_r(4'd3, 4'd7, 4'd12);
        step(4'd0, 1'b1, 1'b0);
        step(4'd3, 1'b1, 1'b0);
        chk("basic_w1", {28'd0, bus.out_data}, 32'd3);
        set_r(4'd1, 4'd1, 4'd1);              // later changes must be ignored
        step(4'd0, 1'b1, 1'b0);
        chk("basic_w2", {28'd0, bus.out_data}, 32'd7);
        step(4'd0, 1'b1, 1'b0);
        chk("basic_w3", {28'd0, bus.out_data}, 32'd12);
        chk("basic_last", {31'd0, bus.out_last}, 32'd1);
        step(4'd0, 1'b1, 1'b0);
        chk("basic_frames", {24'd0, frames}, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd0);

        // Backpressure
        set_r(4'd3, 4'd7, 4'd12);
        step(4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'd3, 1'b0, 1'b0);
        chk("bp_hold", {28'd0, bus.out_data}, 32'd3);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        step(4'd0, 1'b1, 1'b0);
        chk("bp_w2", {28'd0, bus.out_data}, 32'd7);
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        chk("bp_frames", {24'd0, frames}, 32'd2);

        // Overrun
        do_reset();
        set_r(4'd3, 4'd7, 4'd12);
        step(4'd3, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        set_r(4'd5, 4'd5, 4'd5);
        step(4'd3, 1'b0, 1'b0);               // event while in SEND2
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_w2", {28'd0, bus.out_data}, 32'd7);
        step(4'd0, 1'b1, 1'b0);
        chk("ovr_w3", {28'd0, bus.out_data}, 32'd12);
        step(4'd0, 1'b1, 1'b0);
        chk("ovr_frames", {24'd0, frames}, 32'd1);
        step(4'd0, 1'b0, 1'b1);
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        step(4'd0, 1'b0, 1'b0);

        // Back-to-back
        do_reset();
        set_r(4'd3, 4'd7, 4'd12);
        step(4'd3, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        set_r(4'd9, 4'd1, 4'd15);
        step(4'd3, 1'b1, 1'b0);               // event on the final transfer
        chk("b2b_w1", {28'd0, bus.out_data}, 32'd9);
        chk("b2b_ovr", {31'd0, overrun}, 32'd0);
        chk("b2b_f1", {24'd0, frames}, 32'd1);
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        chk("b2b_w3", {28'd0, bus.out_data}, 32'd15);
        step(4'd0, 1'b1, 1'b0);
        chk("b2b_f2", {24'd0, frames}, 32'd2);

        // Mid-frame reset, PS held at the done state across release
        set_r(4'd3, 4'd7, 4'd12);
        step(4'd3, 1'b1, 1'b0);
        step(4'd3, 1'b1, 1'b0);               // now in SEND2
        do_reset();
        chk("mrst_frames", {24'd0, frames}, 32'd0);
        set_r(4'd6, 4'd2, 4'd4);
        step(4'd3, 1'b1, 1'b0);
        chk("mrst_new", {28'd0, bus.out_data}, 32'd6);
        step(4'd3, 1'b1, 1'b0);
        step(4'd3, 1'b1, 1'b0);
        step(4'd3, 1'b1, 1'b0);
        chk("mrst_f1", {24'd0, frames}, 32'd1);

        // Wrap: 256 back-to-back frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            set_r(4'($urandom), 4'($urandom), 4'($urandom));
            step(4'd3, 1'b1, 1'b0);
            step(4'd0, 1'b1, 1'b0);
            step(4'd0, 1'b1, 1'b0);
        end
        step(4'd0, 1'b1, 1'b0);
        chk("wrap_frames", {24'd0, frames}, 32'd0);
        chk("wrap_ovr", {31'd0, overrun}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            set_r(4'($urandom), 4'($urandom), 4'($urandom));
            step(($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fsmd_result_reader
`default_nettype wire
